// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//
// Conditions the raw asynchronous stimulus bit before it reaches the `hello`
// stage.  The input is brought into the clock domain by a two-flop
// synchroniser.  A four-state FSM then accepts a new level only after
// STABLE_CYCLES consecutive synchronised samples at that level.  The clean
// level drives `hello` input A.  The block also produces one-cycle rise/fall
// pulses and a wrapping transition counter.  Every output is a flop, so there
// is no combinational path from din to any output.
//
// Parameters:
//   STABLE_CYCLES  consecutive samples needed to accept a new level (>= 1)
//   CNT_W          width of the qualification counter (holds STABLE_CYCLES-1)
//   EDGE_CNT_W     width of edge_count
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   din         in   raw asynchronous level
//   en          in   filter enable; 0 freezes dout and aborts qualification
//   dout        out  debounced level (feeds hello.A)
//   rise        out  one-cycle pulse on dout 0->1
//   fall        out  one-cycle pulse on dout 1->0
//   busy        out  high while a candidate transition is being qualified
//   edge_count  out  number of dout transitions, modulo 2^EDGE_CNT_W
// ---------------------------------------------------------------------------
module input_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8,
    parameter int EDGE_CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  en,
    output logic                  dout,
    output logic                  rise,
    output logic                  fall,
    output logic                  busy,
    output logic [EDGE_CNT_W-1:0] edge_count
);

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] CHK_HI    = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] CHK_LO    = 2'd3;

    // Count value at which the final qualifying sample is being taken.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // With a single-sample window the check states are skipped entirely.
    localparam bit               ONE_SHOT = (STABLE_CYCLES == 1);

    // Synchroniser
    logic r_s1, r_s2;

    // FSM and outputs
    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_dout;
    logic                  r_rise;
    logic                  r_fall;
    logic                  r_busy;
    logic [EDGE_CNT_W-1:0] r_edge_cnt;

    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_dout_nxt;
    logic                  w_rise_nxt;
    logic                  w_fall_nxt;
    logic                  w_busy_nxt;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser; runs regardless of en so that s2 is already
    // current when the filter is re-enabled.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic.  A sample at the old level, or en dropping, during
    // qualification returns to the stable state with the counter cleared:
    // a restart gets no credit for samples already seen.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        case (r_state)
            STABLE_LO: begin
                if (en && r_s2) begin
                    if (ONE_SHOT) begin
                        w_state_nxt = STABLE_HI;
                        w_dout_nxt  = 1'b1;
                        w_rise_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        // This sample is the first of the window.
                        w_state_nxt = CHK_HI;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end

            CHK_HI: begin
                if (!en || !r_s2) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_HI;
                    w_dout_nxt  = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end

            STABLE_HI: begin
                if (en && !r_s2) begin
                    if (ONE_SHOT) begin
                        w_state_nxt = STABLE_LO;
                        w_dout_nxt  = 1'b0;
                        w_fall_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = CHK_LO;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end

            CHK_LO: begin
                if (!en || r_s2) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = STABLE_LO;
                    w_dout_nxt  = 1'b0;
                    w_fall_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = STABLE_LO;
                w_cnt_nxt   = '0;
                w_dout_nxt  = 1'b0;
            end
        endcase

        // busy is registered from the next state so it tracks r_state exactly.
        w_busy_nxt = (w_state_nxt == CHK_HI) || (w_state_nxt == CHK_LO);
    end

    // -----------------------------------------------------------------------
    // State and output registers.  rise/fall are only set on the accepting
    // edge and default to 0, so they last one cycle and are exclusive.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= STABLE_LO;
            r_cnt      <= '0;
            r_dout     <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_busy     <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
            // Wraps silently at 2^EDGE_CNT_W.
            if (w_rise_nxt || w_fall_nxt)
                r_edge_cnt <= r_edge_cnt + 1'b1;
        end
    end

    assign dout       = r_dout;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign busy       = r_busy;
    assign edge_count = r_edge_cnt;

endmodule

// File: tb/tb_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed bench for input_debouncer.  Inputs are driven just after the
// falling edge and outputs sampled at the falling edge, so "k edges later"
// means k rising edges after the input change.  A second instance with a
// 2-bit edge counter shares all inputs and is used for the wrap scenario.
// ---------------------------------------------------------------------------
module tb_input_debouncer;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       en;
    logic       dout, rise, fall, busy;
    logic [7:0] edge_count;
    logic       w_dout, w_rise, w_fall, w_busy;
    logic [1:0] w_edge_count;

    int n_tests = 0;
    int n_fail  = 0;

    input_debouncer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .en         (en),
        .dout       (dout),
        .rise       (rise),
        .fall       (fall),
        .busy       (busy),
        .edge_count (edge_count)
    );

    input_debouncer #(.EDGE_CNT_W(2)) dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .en         (en),
        .dout       (w_dout),
        .rise       (w_rise),
        .fall       (w_fall),
        .busy       (w_busy),
        .edge_count (w_edge_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        din   = 1'b0;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Check dout/rise/fall/busy one cycle at a time for k = 1..n edges after
    // a din change.  Level changes at edge 6; busy during edges 3..5.
    task automatic check_transition(input string name, input logic new_lvl, input int n);
        logic exp_d, exp_r, exp_f, exp_b;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            exp_d = (k >= 6) ? new_lvl : ~new_lvl;
            exp_r = (k == 6) &&  new_lvl;
            exp_f = (k == 6) && !new_lvl;
            exp_b = (k >= 3) && (k <= 5);
            n_tests++;
            if ({dout, rise, fall, busy} !== {exp_d, exp_r, exp_f, exp_b}) begin
                n_fail++;
                $display("FAIL %s k=%0d {dout,rise,fall,busy} got %b%b%b%b exp %b%b%b%b",
                         name, k, dout, rise, fall, busy, exp_d, exp_r, exp_f, exp_b);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        din   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            din = ~din;
            n_tests++;
            if ({dout, rise, fall, busy, edge_count} !== 12'd0) begin
                n_fail++;
                $display("FAIL reset_hold i=%0d outputs got %b%b%b%b ec=%0d exp all 0",
                         i, dout, rise, fall, busy, edge_count);
            end
        end
        din   = 1'b1;
        rst_n = 1'b1;
        check_transition("reset_release", 1'b1, 6);
        n_tests++;
        if (edge_count !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_release edge_count got %0d exp 1", edge_count);
        end
        @(negedge clk);
        n_tests++;
        if (rise !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release rise_one_cycle got %b exp 0", rise);
        end
    endtask

    task automatic test_clean_edges();
        do_reset();
        din = 1'b1;
        check_transition("clean_rise", 1'b1, 6);
        repeat (14) @(negedge clk);
        din = 1'b0;
        check_transition("clean_fall", 1'b0, 8);
        n_tests++;
        if (edge_count !== 8'd2) begin
            n_fail++;
            $display("FAIL clean_edges edge_count got %0d exp 2", edge_count);
        end
    endtask

    task automatic test_glitch_reject();
        logic exp_b;
        do_reset();
        din = 1'b1;
        repeat (3) @(negedge clk);
        din = 1'b0;
        // s2 high at edges 2..4, seen by the FSM at edges 3..5: busy there,
        // cleared at edge 6 when the low sample aborts the window.
        for (int k = 4; k <= 12; k++) begin
            @(negedge clk);
            exp_b = (k <= 5);
            n_tests++;
            if ({dout, rise, fall, busy} !== {1'b0, 1'b0, 1'b0, exp_b}) begin
                n_fail++;
                $display("FAIL glitch k=%0d {dout,rise,fall,busy} got %b%b%b%b exp 000%b",
                         k, dout, rise, fall, busy, exp_b);
            end
        end
        n_tests++;
        if (edge_count !== 8'd0) begin
            n_fail++;
            $display("FAIL glitch edge_count got %0d exp 0", edge_count);
        end
    endtask

    task automatic test_enable();
        do_reset();
        en  = 1'b0;
        din = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if ({dout, rise, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL enable_off i=%0d {dout,rise,busy} got %b%b%b exp 000",
                         i, dout, rise, busy);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_tests++;
            if ({dout, rise} !== {(k >= 4) ? 1'b1 : 1'b0, (k == 4) ? 1'b1 : 1'b0}) begin
                n_fail++;
                $display("FAIL enable_on k=%0d {dout,rise} got %b%b exp %b%b",
                         k, dout, rise, k >= 4, k == 4);
            end
        end
        // Drop en mid-qualification of a fall: the window is aborted.
        din = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL enable_abort busy_before got %b exp 1", busy);
        end
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if ({dout, fall, busy} !== 3'b100) begin
                n_fail++;
                $display("FAIL enable_abort i=%0d {dout,fall,busy} got %b%b%b exp 100",
                         i, dout, fall, busy);
            end
        end
        n_tests++;
        if (edge_count !== 8'd1) begin
            n_fail++;
            $display("FAIL enable edge_count got %0d exp 1", edge_count);
        end
        en = 1'b1;
    endtask

    task automatic test_wrap();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        do_reset();
        for (int t = 0; t < 5; t++) begin
            din = ~din;
            repeat (6) @(negedge clk);
            n_tests++;
            if (w_edge_count !== exp_seq[t]) begin
                n_fail++;
                $display("FAIL wrap t=%0d edge_count got %0d exp %0d",
                         t, w_edge_count, exp_seq[t]);
            end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        din = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || dut.r_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL async_rst pre busy=%b cnt=%0d exp busy=1 cnt=2", busy, dut.r_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, rise, dout} !== 3'b000 || dut.r_cnt !== 8'd0 || dut.r_state !== 2'd0) begin
            n_fail++;
            $display("FAIL async_rst clear busy=%b rise=%b dout=%b cnt=%0d state=%0d exp all 0",
                     busy, rise, dout, dut.r_cnt, dut.r_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_transition("async_rst_release", 1'b1, 6);
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 1'b0;
        en    = 1'b1;
        test_reset();
        test_clean_edges();
        test_glitch_reject();
        test_enable();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
